// File: rtl/seg7_scan_display.sv
`timescale 1ns/1ps
// seg7_scan_display
//  Display stage behind the 8-bit up/down counter. Whenever the incoming
//  count changes, it is converted to three BCD digits by a sequential
//  shift-add-3 (double-dabble) engine. Those digits are then shown on a
//  3-digit multiplexed 7-segment display, with leading zeros blanked.
//
//  Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; clears all state
//   q_in   : 8-bit binary count, synchronous to clk
//   seg    : registered segment drive {g,f,e,d,c,b,a}
//   an     : registered one-hot digit enables (0=ones, 1=tens, 2=hundreds)
//   busy   : high while a conversion is in progress (CONV or LOAD)
module seg7_scan_display #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] q_in,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    // Codes are built active-low and flipped once for active-high boards.
    localparam logic [6:0] SEG_POL = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
    localparam logic [2:0] AN_POL  = (ACTIVE_LOW != 0) ? 3'h0  : 3'h7;
    localparam logic [6:0] BLANK   = 7'b1111111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // ---------------- converter ----------------
    logic [1:0]  state_q, state_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [11:0] bcd_adj;
    logic [19:0] shifted;

    // Add 3 to each nibble that would overflow past 9 once doubled.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5)
                                      ? bcd_q[gi*4 +: 4] + 4'd3
                                      : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {bcd_adj, bin_q} << 1;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        case (state_q)
            IDLE: begin
                if (q_in != shadow_q) begin
                    shadow_d  = q_in;
                    bin_d     = q_in;
                    bcd_d     = 12'd0;
                    bit_cnt_d = 3'd0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                bcd_d     = shifted[19:8];
                bin_d     = shifted[7:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shadow_q  <= 8'd0;
            bin_q     <= 8'd0;
            bcd_q     <= 12'd0;
            bit_cnt_q <= 3'd0;
            hund_q    <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
        end
    end

    assign busy = (state_q == CONV) || (state_q == LOAD);

    // ---------------- display scan ----------------
    logic [PW-1:0] presc_q;
    logic [1:0]    sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          wrap;

    assign wrap = (presc_q == PRESC_MAX);

    // seg/an are computed for the digit about to be selected so that all
    // three registers change on the same edge.
    always_comb begin
        sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        case (sel_d)
            2'd0:    seg_d = seg7(ones_q);
            2'd1:    seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? BLANK : seg7(tens_q);
            default: seg_d = (hund_q == 4'd0) ? BLANK : seg7(hund_q);
        endcase
        an_d = ~(3'b001 << sel_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            sel_q   <= 2'd0;
            an_q    <= 3'b110 ^ AN_POL;
            seg_q   <= 7'b1000000 ^ SEG_POL;
        end else if (wrap) begin
            presc_q <= '0;
            sel_q   <= sel_d;
            an_q    <= an_d ^ AN_POL;
            seg_q   <= seg_d ^ SEG_POL;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
